wb_arbiter: RTL and testbench

Parametrised write-back arbiter for the cpu core. It merges results from `NCH` execution units (ALU, MEM, and later units) onto the single register-file write port. Each channel gets a `DEPTH`-entry queue with its own `ok` back-pressure. Channels are served round-robin, and the block replaces the fixed two-input `write_back` stage, sitting between the execution units and `register_manager` (`res_data` / `res_adr` / `res_v`).

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_arbiter_fifo.sv | 63 ++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_configuration : shared core constants and the write-back entry type
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_configuration;

    localparam int XLEN      = 32;
    localparam int REG_ADR_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [REG_ADR_W-1:0] rd;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_arbiter_if : producer channels and register-file write port
// Rev 1.0
// ----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NCH  = 2
);
    import cpu_configuration::*;

    logic [NCH*XLEN-1:0]      ch_res_i;
    logic [NCH*REG_ADR_W-1:0] ch_rd_i;
    logic [NCH-1:0]           ch_v_i;
    logic [NCH-1:0]           ch_ok_o;
    logic                     rf_ready_i;
    logic [XLEN-1:0]          result_o;
    logic [REG_ADR_W-1:0]     rd_o;
    logic                     result_v_o;
    logic [NCH-1:0]           ch_empty_o;

    modport slave (
        input  ch_res_i, ch_rd_i, ch_v_i, rf_ready_i,
        output ch_ok_o, result_o, rd_o, result_v_o, ch_empty_o
    );

    modport master (
        output ch_res_i, ch_rd_i, ch_v_i, rf_ready_i,
        input  ch_ok_o, result_o, rd_o, result_v_o, ch_empty_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_fifo : per-channel circular queue of write-back entries
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_fifo
    import cpu_configuration::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire T                       push_data_i,
    input  wire logic                   pop_i,
    output T                            head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_arbiter : round-robin merge of NCH result queues onto one RF write port
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN  = cpu_configuration::XLEN,
    parameter int NCH   = 2,
    parameter int DEPTH = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    wb_arbiter_if.slave  bus
);
    import cpu_configuration::*;

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [REG_ADR_W-1:0] rd;
    } entry_t;

    entry_t          head [NCH];
    logic [CW-1:0]   count [NCH];
    logic [NCH-1:0]  push;
    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  ok;

    logic            can_load;
    logic            gnt_v;
    logic [GW-1:0]   gnt_idx;
    logic [GW-1:0]   rr_ptr_q;
    logic [GW-1:0]   rr_ptr_d;
    entry_t          out_q;
    logic            out_v_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        entry_t in_entry;

        assign in_entry.data = bus.ch_res_i[i*XLEN +: XLEN];
        assign in_entry.rd   = bus.ch_rd_i[i*REG_ADR_W +: REG_ADR_W];
        assign ok[i]         = (count[i] != FULL_CNT);
        // Writes to x0 complete the handshake but are dropped here.
        assign push[i]       = bus.ch_v_i[i] && !full[i] && (in_entry.rd != '0);
        assign pop[i]        = gnt_v && (gnt_idx == GW'(i));

        wb_fifo #(
            .DEPTH (DEPTH),
            .T     (entry_t)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[i]),
            .push_data_i (in_entry),
            .pop_i       (pop[i]),
            .head_o      (head[i]),
            .count_o     (count[i]),
            .full_o      (full[i]),
            .empty_o     (empty[i])
        );
    end

    assign can_load = !out_v_q || bus.rf_ready_i;

    // Search from rr_ptr upwards; scanning in reverse lets the nearest hit win.
    always_comb begin
        int idx;
        int nxt;
        idx      = 0;
        nxt      = 0;
        gnt_v    = 1'b0;
        gnt_idx  = '0;
        if (can_load) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!empty[idx]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = GW'(idx);
                end
            end
        end
        nxt = int'(gnt_idx) + 1;
        if (nxt >= NCH) begin
            nxt = 0;
        end
        rr_ptr_d = gnt_v ? GW'(nxt) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (gnt_v) begin
                out_q   <= head[gnt_idx];
                out_v_q <= 1'b1;
            end else if (bus.rf_ready_i) begin
                out_v_q <= 1'b0;
            end
        end
    end

    assign bus.ch_ok_o    = ok;
    assign bus.ch_empty_o = empty;
    assign bus.result_o   = out_q.data;
    assign bus.rd_o       = out_q.rd;
    assign bus.result_v_o = out_v_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_arbiter : directed stimulus with queue-based scoreboards for NCH=2/3
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32), .NCH(2)) bus2 ();
    wb_arbiter_if #(.XLEN(32), .NCH(3)) bus3 ();

    wb_arbiter #(.XLEN(32), .NCH(2), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    wb_arbiter #(.XLEN(32), .NCH(3), .DEPTH(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
    } exp_t;

    exp_t sb2[$];
    exp_t sb3[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send2(input int ch, input logic [31:0] d, input logic [4:0] r);
        bus2.ch_res_i[ch*32 +: 32] = d;
        bus2.ch_rd_i[ch*5 +: 5]    = r;
        bus2.ch_v_i[ch]            = 1'b1;
    endtask

    task automatic exp2(input logic [31:0] d, input logic [4:0] r);
        exp_t e;
        e.d = d;
        e.r = r;
        sb2.push_back(e);
    endtask

    task automatic exp3(input logic [31:0] d, input logic [4:0] r);
        exp_t e;
        e.d = d;
        e.r = r;
        sb3.push_back(e);
    endtask

    // Scoreboard monitors: every accepted write must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus2.result_v_o && bus2.rf_ready_i) begin
            exp_t e;
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL sb2_unexpected: got data=0x%0h rd=%0d expected no write",
                         bus2.result_o, bus2.rd_o);
            end else begin
                e = sb2.pop_front();
                if (bus2.result_o !== e.d || bus2.rd_o !== e.r) begin
                    errors++;
                    $display("FAIL sb2_write: got data=0x%0h rd=%0d expected data=0x%0h rd=%0d",
                             bus2.result_o, bus2.rd_o, e.d, e.r);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus3.result_v_o && bus3.rf_ready_i) begin
            exp_t e;
            checks++;
            if (sb3.size() == 0) begin
                errors++;
                $display("FAIL sb3_unexpected: got data=0x%0h rd=%0d expected no write",
                         bus3.result_o, bus3.rd_o);
            end else begin
                e = sb3.pop_front();
                if (bus3.result_o !== e.d || bus3.rd_o !== e.r) begin
                    errors++;
                    $display("FAIL sb3_write: got data=0x%0h rd=%0d expected data=0x%0h rd=%0d",
                             bus3.result_o, bus3.rd_o, e.d, e.r);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus2.ch_res_i   = '0;
        bus2.ch_rd_i    = '0;
        bus2.ch_v_i     = '0;
        bus2.rf_ready_i = 1'b1;
        bus3.ch_res_i   = '0;
        bus3.ch_rd_i    = '0;
        bus3.ch_v_i     = '0;
        bus3.rf_ready_i = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_result_v", 32'(bus2.result_v_o), 32'd0);
        chk("rst_result",   bus2.result_o,        32'd0);
        chk("rst_rd",       32'(bus2.rd_o),       32'd0);
        chk("rst_ok",       32'(bus2.ch_ok_o),    32'd3);
        chk("rst_empty",    32'(bus2.ch_empty_o), 32'd3);
        chk("rst3_result_v", 32'(bus3.result_v_o), 32'd0);
        rst = 1'b0;

        // Single write: valid two edges after the transfer
        send2(0, 32'hDEADBEEF, 5'd5);
        exp2(32'hDEADBEEF, 5'd5);
        tick();
        bus2.ch_v_i = '0;
        chk("t1_v_after_E", 32'(bus2.result_v_o), 32'd0);
        tick();
        chk("t1_v_after_E1", 32'(bus2.result_v_o), 32'd1);
        chk("t1_result", bus2.result_o, 32'hDEADBEEF);
        chk("t1_rd", 32'(bus2.rd_o), 32'd5);
        tick();
        chk("t1_v_clear", 32'(bus2.result_v_o), 32'd0);

        // A channel-1 write moves rr_ptr back to 0
        send2(1, 32'h33, 5'd3);
        exp2(32'h33, 5'd3);
        tick();
        bus2.ch_v_i = '0;
        tick();
        tick();

        // Simultaneous channels, twice
        for (int rep = 0; rep < 2; rep++) begin
            send2(0, 32'h11, 5'd1);
            send2(1, 32'h22, 5'd2);
            exp2(32'h11, 5'd1);
            exp2(32'h22, 5'd2);
            tick();
            bus2.ch_v_i = '0;
            tick();
            chk("t2_first", bus2.result_o, 32'h11);
            tick();
            chk("t2_second", bus2.result_o, 32'h22);
            tick();
            chk("t2_idle", 32'(bus2.result_v_o), 32'd0);
        end

        // Back-pressure on channel 1
        bus2.rf_ready_i = 1'b0;
        send2(1, 32'hA1, 5'd7);
        exp2(32'hA1, 5'd7);
        tick();
        send2(1, 32'hA2, 5'd8);
        exp2(32'hA2, 5'd8);
        tick();
        send2(1, 32'hA3, 5'd9);
        exp2(32'hA3, 5'd9);
        tick();
        bus2.ch_v_i = '0;
        chk("t3_ok_full", 32'(bus2.ch_ok_o), 32'd1);
        chk("t3_head_out", bus2.result_o, 32'hA1);
        send2(1, 32'hA4, 5'd10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_v",    32'(bus2.result_v_o), 32'd1);
            chk("t3_hold_data", bus2.result_o,        32'hA1);
            chk("t3_hold_rd",   32'(bus2.rd_o),       32'd7);
            chk("t3_hold_ok",   32'(bus2.ch_ok_o),    32'd1);
        end
        bus2.ch_v_i     = '0;
        bus2.rf_ready_i = 1'b1;
        tick();
        chk("t3_ok_reopen", 32'(bus2.ch_ok_o), 32'd3);
        chk("t3_second", bus2.result_o, 32'hA2);
        tick();
        chk("t3_third", bus2.result_o, 32'hA3);
        tick();
        chk("t3_drained_v", 32'(bus2.result_v_o), 32'd0);
        chk("t3_drained_empty", 32'(bus2.ch_empty_o), 32'd3);

        // x0 filter
        send2(0, 32'h55, 5'd0);
        chk("t4_ok", 32'(bus2.ch_ok_o[0]), 32'd1);
        tick();
        bus2.ch_v_i = '0;
        chk("t4_empty", 32'(bus2.ch_empty_o[0]), 32'd1);
        tick();
        tick();
        chk("t4_no_write", 32'(bus2.result_v_o), 32'd0);

        // Fairness with three channels
        bus3.ch_res_i = {32'hC0, 32'hB0, 32'hA0};
        bus3.ch_rd_i  = {5'd12, 5'd11, 5'd10};
        bus3.ch_v_i   = 3'b111;
        tick();
        bus3.ch_res_i = {32'hC1, 32'hB1, 32'hA1};
        bus3.ch_rd_i  = {5'd15, 5'd14, 5'd13};
        tick();
        bus3.ch_v_i = '0;
        exp3(32'hA0, 5'd10);
        exp3(32'hB0, 5'd11);
        exp3(32'hC0, 5'd12);
        exp3(32'hA1, 5'd13);
        exp3(32'hB1, 5'd14);
        exp3(32'hC1, 5'd15);
        for (int k = 0; k < 6; k++) begin
            chk("t5_stream_v", 32'(bus3.result_v_o), 32'd1);
            tick();
        end
        chk("t5_done", 32'(bus3.result_v_o), 32'd0);

        // Mid-flight reset discards everything
        bus2.rf_ready_i = 1'b0;
        send2(0, 32'h66, 5'd20);
        send2(1, 32'h77, 5'd21);
        tick();
        tick();
        tick();
        bus2.ch_v_i = '0;
        chk("t6_filled", 32'(bus2.ch_ok_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_v",      32'(bus2.result_v_o), 32'd0);
        chk("t6_result", bus2.result_o,        32'd0);
        chk("t6_rd",     32'(bus2.rd_o),       32'd0);
        chk("t6_empty",  32'(bus2.ch_empty_o), 32'd3);
        chk("t6_ok",     32'(bus2.ch_ok_o),    32'd3);
        bus2.rf_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        chk("t6_no_stale", 32'(bus2.result_v_o), 32'd0);

        chk("sb2_drained", 32'(sb2.size()), 32'd0);
        chk("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
